// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bus: fetch packet in, two decoder bundles out, pop/flush back.
interface fetch_queue_if;
  logic         flush;
  logic [1:0]   in_valid;
  logic         in_ready;
  logic [31:0]  in_pc0;
  logic [31:0]  in_pc1;
  logic [31:0]  in_pc_next0;
  logic [31:0]  in_pc_next1;
  logic [31:0]  in_inst0;
  logic [31:0]  in_inst1;
  logic [6:0]   in_exception0;
  logic [6:0]   in_exception1;
  logic [31:0]  in_badv0;
  logic [31:0]  in_badv1;
  logic         in_unknown0;
  logic         in_unknown1;
  logic [136:0] out0;
  logic [136:0] out1;
  logic [1:0]   pop;

  // Fetch/decode side driving the queue
  modport master (
    output flush, in_valid, in_pc0, in_pc1, in_pc_next0, in_pc_next1,
           in_inst0, in_inst1, in_exception0, in_exception1,
           in_badv0, in_badv1, in_unknown0, in_unknown1, pop,
    input  in_ready, out0, out1
  );

  // The queue itself
  modport slave (
    input  flush, in_valid, in_pc0, in_pc1, in_pc_next0, in_pc_next1,
           in_inst0, in_inst1, in_exception0, in_exception1,
           in_badv0, in_badv1, in_unknown0, in_unknown1, pop,
    output in_ready, out0, out1
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer between fetch (2-wide
// push) and decode (2-wide pop). Outputs are decoded from registers only.
module fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 136;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [1:0]    avail;
  logic [1:0]    push_n;
  logic          pop_ok;
  logic          do_push;
  logic          we0;
  logic          we1;
  logic [EW-1:0] ent0;
  logic [EW-1:0] ent1;

  // Entry packing: {unknown, badv, exception, pc_next, pc, inst}
  assign ent0 = {bus.in_unknown0, bus.in_badv0, bus.in_exception0,
                 bus.in_pc_next0, bus.in_pc0, bus.in_inst0};
  assign ent1 = {bus.in_unknown1, bus.in_badv1, bus.in_exception1,
                 bus.in_pc_next1, bus.in_pc1, bus.in_inst1};

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Ready leaves room for a full 2-wide packet; registered count only
  assign bus.in_ready = (count_q <= CW'(DEPTH - 2));

  // Pop is legal only up to the number of presented entries
  assign avail  = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
  assign pop_ok = (bus.pop <= avail);

  assign do_push = bus.in_ready && bus.in_valid[0];
  assign push_n  = do_push ? (bus.in_valid[1] ? 2'd2 : 2'd1) : 2'd0;

  // Next-state pointers and count; flush wins, illegal pop freezes state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we0     = 1'b0;
    we1     = 1'b0;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (pop_ok) begin
      head_d  = head_q + AW'(bus.pop);
      tail_d  = tail_q + AW'(push_n);
      count_d = count_q + CW'(push_n) - CW'(bus.pop);
      we0     = do_push;
      we1     = do_push && bus.in_valid[1];
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array, intentionally not reset; occupancy gates visibility
  always_ff @(posedge clk) begin
    if (we0) mem_q[tail_q]  <= ent0;
    if (we1) mem_q[tail_p1] <= ent1;
  end

  // Decoder bundles, zero when the slot is not occupied
  assign bus.out0 = (count_q != '0)        ? {1'b1, mem_q[head_q]}  : '0;
  assign bus.out1 = (count_q >= CW'(2))    ? {1'b1, mem_q[head_p1]} : '0;

  a_pop_legal : assert property (@(posedge clk) disable iff (rst) bus.pop <= avail);
  a_valid_legal : assert property (@(posedge clk) disable iff (rst) bus.in_valid != 2'b10);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus a
// negedge monitor comparing every presented output against it.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 8;

  typedef logic [135:0] entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  entry_t exp_q[$];
  int     total = 0;
  int     bad   = 0;
  bit     model_ready;

  task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [136:0] exp_out(input int idx);
    if (exp_q.size() > idx) return {1'b1, exp_q[idx]};
    return '0;
  endfunction

  // Reference model: FIFO of accepted entries; pops from front, pushes to back
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (bus.flush) begin
      exp_q.delete();
    end else begin
      model_ready = (exp_q.size() <= int'(DEPTH) - 2);
      for (int i = 0; i < int'(bus.pop); i++) void'(exp_q.pop_front());
      if (model_ready && bus.in_valid[0])
        exp_q.push_back({bus.in_unknown0, bus.in_badv0, bus.in_exception0,
                         bus.in_pc_next0, bus.in_pc0, bus.in_inst0});
      if (model_ready && bus.in_valid == 2'b11)
        exp_q.push_back({bus.in_unknown1, bus.in_badv1, bus.in_exception1,
                         bus.in_pc_next1, bus.in_pc1, bus.in_inst1});
    end
  end

  // Monitor: compare outputs against the model head every cycle
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 137'(bus.in_ready), 137'(exp_q.size() <= int'(DEPTH) - 2));
      check("out0", bus.out0, exp_out(0));
      check("out1", bus.out1, exp_out(1));
    end
  end

  task automatic rand_pkt();
    bus.in_pc0        = $urandom;
    bus.in_pc1        = $urandom;
    bus.in_pc_next0   = $urandom;
    bus.in_pc_next1   = $urandom;
    bus.in_inst0      = $urandom;
    bus.in_inst1      = $urandom;
    bus.in_badv0      = $urandom;
    bus.in_badv1      = $urandom;
    bus.in_exception0 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
    bus.in_exception1 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
    bus.in_unknown0   = 1'($urandom);
    bus.in_unknown1   = 1'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [1:0] v, input logic [1:0] p, input logic f);
    rand_pkt();
    bus.in_valid = v;
    bus.pop      = p;
    bus.flush    = f;
    step();
  endtask

  initial begin
    int n;
    int maxp;
    logic [1:0] v;
    bus.flush    = 1'b0;
    bus.in_valid = 2'b00;
    bus.pop      = 2'd0;
    rand_pkt();

    // Held in reset across a clock edge
    #12;
    check("rst_out0", bus.out0, '0);
    check("rst_out1", bus.out1, '0);
    check("rst_ready", 137'(bus.in_ready), 137'(1));
    rst = 1'b0;
    step();

    // Fill with ordered pcs, then drain two per cycle
    for (int i = 0; i < 4; i++) begin
      rand_pkt();
      bus.in_pc0   = 32'h1c000000 + 32'(8 * i);
      bus.in_pc1   = 32'h1c000004 + 32'(8 * i);
      bus.in_valid = 2'b11;
      bus.pop      = 2'd0;
      step();
    end
    check("fill_ready", 137'(bus.in_ready), 137'(0));
    for (int i = 0; i < 4; i++) begin
      check("drain_pc0", 137'(bus.out0[63:32]), 137'(32'h1c000000 + 32'(8 * i)));
      check("drain_pc1", 137'(bus.out1[63:32]), 137'(32'h1c000004 + 32'(8 * i)));
      cyc(2'b00, 2'd2, 1'b0);
    end
    check("drain_empty", 137'(bus.out0[136]), 137'(0));

    // Single slot push
    rand_pkt();
    bus.in_pc0   = 32'h1c000100;
    bus.in_valid = 2'b01;
    bus.pop      = 2'd0;
    step();
    bus.in_valid = 2'b00;
    check("single_pc", 137'(bus.out0[63:32]), 137'(32'h1c000100));
    check("single_nempty", 137'(bus.out0[136]), 137'(1));
    check("single_out1", bus.out1, '0);
    cyc(2'b00, 2'd1, 1'b0);

    // Steady state push 2 / pop 2 wraps the pointers
    cyc(2'b11, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(2'b11, 2'd2, 1'b0);
    cyc(2'b00, 2'd2, 1'b0);

    // Flush with simultaneous push and pop at count 5
    cyc(2'b11, 2'd0, 1'b0);
    cyc(2'b11, 2'd0, 1'b0);
    cyc(2'b01, 2'd0, 1'b0);
    cyc(2'b11, 2'd2, 1'b1);
    bus.flush = 1'b0;
    check("flush_out0", bus.out0, '0);
    check("flush_out1", bus.out1, '0);
    check("flush_ready", 137'(bus.in_ready), 137'(1));

    // Exception passthrough on slot1
    rand_pkt();
    bus.in_valid      = 2'b11;
    bus.pop           = 2'd0;
    bus.in_exception1 = 7'h08;
    bus.in_badv1      = 32'hdeadbeef;
    step();
    check("exc_code", 137'(bus.out1[102:96]), 137'(7'h08));
    check("exc_badv", 137'(bus.out1[134:103]), 137'(32'hdeadbeef));
    cyc(2'b00, 2'd2, 1'b0);

    // Asynchronous reset mid-cycle at count 6
    cyc(2'b11, 2'd0, 1'b0);
    cyc(2'b11, 2'd0, 1'b0);
    cyc(2'b11, 2'd0, 1'b0);
    bus.in_valid = 2'b00;
    bus.pop      = 2'd0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_out0", bus.out0, '0);
    check("arst_out1", bus.out1, '0);
    check("arst_ready", 137'(bus.in_ready), 137'(1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();

    // Randomized traffic with legal pops and occasional flush
    for (int i = 0; i < 400; i++) begin
      n = exp_q.size();
      maxp = (n >= 2) ? 2 : n;
      case ($urandom_range(0, 2))
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      cyc(v, 2'($urandom_range(0, maxp)), ($urandom_range(0, 19) == 0));
    end
    cyc(2'b00, 2'd0, 1'b0);
    cyc(2'b00, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port flush, input, 1, discards all queued entries (branch mispredict, exception, ertn).
REQ-005 SHALL have port in_valid, input, 2, per-slot valid of the fetch packet; in_valid=2'b10 is illegal.
REQ-006 SHALL have port in_ready, output, 1, queue accepts a fetch packet this cycle.
REQ-007 SHALL have ports in_pc0/in_pc1, in_pc_next0/in_pc_next1 and in_inst0/in_inst1, input, 32 each, per-slot PC, predicted next PC and instruction word.
REQ-008 SHALL have ports in_exception0/in_exception1 (input, 7), in_badv0/in_badv1 (input, 32) and in_unknown0/in_unknown1 (input, 1), per-slot fetch exception code, bad VA and unknown flag.
REQ-009 SHALL have ports out0 and out1, output, 137 each, decoder bundle {nempty[136], unknown[135], badv[134:103], exception[102:96], pc_next[95:64], pc[63:32], inst[31:0]}.
REQ-010 SHALL have port pop, input, 2, entries consumed by decode this cycle (0, 1 or 2).

Function
REQ-011 SHALL store each entry as 136 bits {unknown, badv, exception, pc_next, pc, inst} in a DEPTH-entry circular buffer.
REQ-012 SHALL keep a head pointer, a tail pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and a count (log2(DEPTH)+1 bits).
REQ-013 SHALL drive in_ready = (count <= DEPTH-2), from registered count only, with no path from pop or flush.
REQ-014 SHALL push when in_ready and in_valid!=0: slot0 goes to tail; if in_valid[1], slot1 goes to tail+1; tail advances by popcount(in_valid).
REQ-015 SHALL ignore in_valid when in_ready=0; upstream holds the packet.
REQ-016 SHALL present the entry at head on out0 with out0[136]=1 when count>=1; out0 SHALL be all-zero when count=0.
REQ-017 SHALL present the entry at head+1 (wrapping) on out1 with out1[136]=1 when count>=2; out1 SHALL be all-zero when count<2.
REQ-018 SHALL make out0/out1 depend only on registers, with no combinational path from in_* or pop.
REQ-019 SHALL advance head by pop and apply count_next = count + pushed - pop, allowing push and pop in the same cycle.
REQ-020 SHALL treat pop greater than the number of valid outputs, or pop=3, as illegal; an assertion SHALL fire in simulation and state SHALL remain unchanged.
REQ-021 SHALL, on flush, set head=tail=0 and count=0 at the next edge, ignoring same-cycle push and pop; out0/out1 SHALL read zero in the following cycle.
REQ-022 SHALL pass exception, badv and unknown through unmodified; entries with a nonzero exception are queued and popped like normal entries.
REQ-023 SHALL preserve program order across wrap-around: an entry written at index DEPTH-1 is followed by index 0.

Reset
REQ-024 SHALL, on rst asserted, immediately clear head, tail and count to 0, independent of clk.
REQ-025 SHALL hold out0=out1=0 and in_ready=1 while in reset and in the first cycle after release.
REQ-026 SHALL leave storage array contents undefined after reset; no output may expose them while count=0.
REQ-027 SHALL, if rst asserts mid-operation, drop all queued entries with no partial push or pop visible afterwards.

Verification
REQ-028 Fill/drain: push 2/cycle for 4 cycles (pcs 0x1c000000..0x1c00001c), pop=0 -> count=8, in_ready=0; then pop=2 for 4 cycles -> outputs appear in pc order, out0[136] is 0 at the end.
REQ-029 Single slot: in_valid=01 with pc=0x1c000100, next cycle pop=0 -> out0[63:32]=0x1c000100, out0[136]=1, out1=0.
REQ-030 Wrap-around: steady push 2/pop 2 for 20 cycles -> pointers wrap, no loss or reorder, count stays constant.
REQ-031 Flush with simultaneous push and pop at count=5 -> next cycle count=0, out0=out1=0, in_ready=1.
REQ-032 Exception passthrough: slot1 with exception=7'h08 and badv=0xdeadbeef -> out bits [102:96]=7'h08 and [134:103]=0xdeadbeef exactly.
REQ-033 Async reset mid-cycle at count=6 -> outputs zero before the next clk edge, and in_ready=1.
